// File: rtl/nes_mem_pkg.sv
// Shared types and constants for the NES main-memory port: arbiter states,
// requester ids and the address-region prefixes of the main_mem logical space.
package nes_mem_pkg;
  localparam int ADDR_W = 22;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_PPU = 1'b1;

  // Region prefixes, MSB-aligned in the 22-bit address.
  localparam logic [0:0] REGION_PRG     = 1'b0;
  localparam logic [1:0] REGION_CHR     = 2'b10;
  localparam logic [3:0] REGION_VRAM    = 4'b1100;
  localparam logic [3:0] REGION_CPURAM  = 4'b1110;
  localparam logic [3:0] REGION_CARTRAM = 4'b1111;

  // Attributes of the access that won arbitration; the address lives
  // separately because its width follows the arbiter parameter.
  typedef struct packed {
    logic       owner;
    logic       we;
    logic [7:0] wdata;
  } acc_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen; index 0 = CPU, 1 = PPU.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);
  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main_mem port between CPU and PPU: one access in flight,
// round-robin on ties, latency-compensated read capture, req/ack per lane.
module mem_arbiter #(
  parameter int ADDR_W = 22,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [7:0]        ppu_wdata,
  output logic              ppu_ack,
  output logic [7:0]        ppu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_cpu,
  output logic              mem_rd_ppu,
  output logic              mem_wr,
  output logic [7:0]        mem_d,
  input  logic [7:0]        mem_q_cpu,
  input  logic [7:0]        mem_q_ppu,
  output logic              busy
);
  import nes_mem_pkg::*;

  localparam logic [3:0] RD_CNT = 4'(RD_LAT);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT);

  arb_state_t        state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        ppu_rdata_q, ppu_rdata_d;
  logic              grant, grant_vld;

  rr_arb2 u_rr (
    .req   ({ppu_req, cpu_req}),
    .last  (last_q),
    .grant (grant),
    .valid (grant_vld)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cpu_rdata_d = cpu_rdata_q;
    ppu_rdata_d = ppu_rdata_q;
    case (state_q)
      IDLE: begin
        if (load_done && grant_vld) begin
          acc_d.owner = grant;
          acc_d.we    = (grant == OWNER_PPU) ? ppu_we    : cpu_we;
          acc_d.wdata = (grant == OWNER_PPU) ? ppu_wdata : cpu_wdata;
          addr_d      = (grant == OWNER_PPU) ? ppu_addr  : cpu_addr;
          last_d      = grant;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = acc_q.we ? WR_CNT : RD_CNT;
        state_d = WAIT;
      end
      WAIT: begin
        // The final WAIT cycle is the one in which main_mem data is valid.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ACK;
          if (!acc_q.we) begin
            if (acc_q.owner == OWNER_PPU) ppu_rdata_d = mem_q_ppu;
            else                          cpu_rdata_d = mem_q_cpu;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      last_q      <= OWNER_PPU;
      cpu_rdata_q <= '0;
      ppu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      cpu_rdata_q <= cpu_rdata_d;
      ppu_rdata_q <= ppu_rdata_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_addr   = addr_q;
  assign mem_d      = acc_q.wdata;
  assign mem_rd_cpu = (state_q == ISSUE) && !acc_q.we && (acc_q.owner == OWNER_CPU);
  assign mem_rd_ppu = (state_q == ISSUE) && !acc_q.we && (acc_q.owner == OWNER_PPU);
  assign mem_wr     = (state_q == ISSUE) &&  acc_q.we;
  assign cpu_ack    = (state_q == ACK) && (acc_q.owner == OWNER_CPU);
  assign ppu_ack    = (state_q == ACK) && (acc_q.owner == OWNER_PPU);
  assign cpu_rdata  = cpu_rdata_q;
  assign ppu_rdata  = ppu_rdata_q;

  always @(posedge clock) begin
    assert (RD_LAT >= 1 && RD_LAT <= 15 && WR_LAT >= 1 && WR_LAT <= 15)
      else $error("mem_arbiter: RD_LAT/WR_LAT outside 1..15");
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single accesses plus hand-written
// sequences for contention, load gating, long latency and reset mid-access.
module tb_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        load_done;
  logic        cpu_req, cpu_we, ppu_req, ppu_we;
  logic [21:0] cpu_addr, ppu_addr;
  logic [7:0]  cpu_wdata, ppu_wdata, mem_q_cpu, mem_q_ppu;

  logic        cpu_ack, ppu_ack, mem_rd_cpu, mem_rd_ppu, mem_wr, busy;
  logic [7:0]  cpu_rdata, ppu_rdata, mem_d;
  logic [21:0] mem_addr;

  logic        d3_cpu_ack, d3_ppu_ack, d3_mem_rd_cpu, d3_mem_rd_ppu, d3_mem_wr, d3_busy;
  logic [7:0]  d3_cpu_rdata, d3_ppu_rdata, d3_mem_d;
  logic [21:0] d3_mem_addr;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(22), .RD_LAT(1), .WR_LAT(1)) u_dut (
    .clock(clock), .reset(reset), .load_done(load_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
    .mem_addr(mem_addr), .mem_rd_cpu(mem_rd_cpu), .mem_rd_ppu(mem_rd_ppu),
    .mem_wr(mem_wr), .mem_d(mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu),
    .busy(busy)
  );

  mem_arbiter #(.ADDR_W(22), .RD_LAT(3), .WR_LAT(2)) u_dut3 (
    .clock(clock), .reset(reset), .load_done(load_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(d3_cpu_ack), .cpu_rdata(d3_cpu_rdata),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .ppu_ack(d3_ppu_ack), .ppu_rdata(d3_ppu_rdata),
    .mem_addr(d3_mem_addr), .mem_rd_cpu(d3_mem_rd_cpu), .mem_rd_ppu(d3_mem_rd_ppu),
    .mem_wr(d3_mem_wr), .mem_d(d3_mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu),
    .busy(d3_busy)
  );

  typedef struct {
    logic        who;      // 0 = CPU, 1 = PPU
    logic        we;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  q;
    logic [7:0]  exp_cpu_rd;
    logic [7:0]  exp_ppu_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ppu_req = 0; ppu_we = 0; ppu_addr = '0; ppu_wdata = '0;
    mem_q_cpu = '0; mem_q_ppu = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    vec_t v;
    int   n, na_cpu, na_ppu, bad;

    vecs[0] = '{1'b0, 1'b0, 22'h380010, 8'h00, 8'hA5, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 22'h300123, 8'h3C, 8'h00, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 22'h000456, 8'h00, 8'h5A, 8'hA5, 8'h5A};
    vecs[3] = '{1'b0, 1'b1, 22'h3FFFFF, 8'hFF, 8'h00, 8'hA5, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 22'h200000, 8'h00, 8'h00, 8'h00, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 22'h3C0000, 8'h00, 8'hC3, 8'h00, 8'hC3};

    load_done = 1;
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    chk("reset_outputs",
        {cpu_ack, cpu_rdata, ppu_ack, ppu_rdata, mem_addr, mem_rd_cpu, mem_rd_ppu,
         mem_wr, mem_d, busy}, 64'd0);

    // Table of isolated accesses: request at cycle 0, strobe 1, wait 2, ack 3.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      cpu_req = ~v.who; ppu_req = v.who;
      cpu_we  = v.we;   ppu_we  = v.we;
      cpu_addr  = v.who ? 22'h0ABCDE : v.addr;
      ppu_addr  = v.who ? v.addr : 22'h0ABCDE;
      cpu_wdata = v.who ? 8'h99 : v.wdata;
      ppu_wdata = v.who ? v.wdata : 8'h99;
      if (v.we) begin
        mem_q_cpu = 8'hEE; mem_q_ppu = 8'hEE;
      end else begin
        mem_q_cpu = v.who ? ~v.q : v.q;
        mem_q_ppu = v.who ? v.q : ~v.q;
      end
      step();
      chk($sformatf("v%0d_strobes", i), {mem_rd_cpu, mem_rd_ppu, mem_wr},
          {!v.we && !v.who, !v.we && v.who, v.we});
      chk($sformatf("v%0d_addr", i), mem_addr, v.addr);
      if (v.we) chk($sformatf("v%0d_wdata", i), mem_d, v.wdata);
      chk($sformatf("v%0d_busy", i), busy, 1);
      step();
      chk($sformatf("v%0d_wait_quiet", i), {mem_rd_cpu, mem_rd_ppu, mem_wr, cpu_ack, ppu_ack}, 0);
      chk($sformatf("v%0d_addr_hold", i), mem_addr, v.addr);
      step();
      chk($sformatf("v%0d_acks", i), {cpu_ack, ppu_ack}, {!v.who, v.who});
      chk($sformatf("v%0d_rdata", i), {cpu_rdata, ppu_rdata}, {v.exp_cpu_rd, v.exp_ppu_rd});
      chk($sformatf("v%0d_ack_addr", i), mem_addr, v.addr);
      cpu_req = 0; ppu_req = 0;
      step();
      chk($sformatf("v%0d_idle", i), {busy, cpu_ack, ppu_ack}, 0);
    end

    // Contention: both hold req; grants alternate starting with CPU.
    do_reset();
    cpu_req = 1; ppu_req = 1; cpu_addr = 22'h001111; ppu_addr = 22'h002222;
    n = 0; na_cpu = 0; na_ppu = 0;
    for (int c = 0; c < 80 && (na_cpu + na_ppu) < 8; c++) begin
      step();
      if (mem_rd_cpu || mem_rd_ppu) begin
        chk($sformatf("contention_grant%0d", n), {mem_rd_ppu, mem_rd_cpu},
            (n % 2 == 0) ? 2'b01 : 2'b10);
        n++;
      end
      if (cpu_ack) na_cpu++;
      if (ppu_ack) na_ppu++;
    end
    cpu_req = 0; ppu_req = 0;
    chk("contention_grants", n, 8);
    chk("contention_cpu_acks", na_cpu, 4);
    chk("contention_ppu_acks", na_ppu, 4);
    step();
    step();

    // Load gating: 20 cycles with load_done low, then release.
    do_reset();
    load_done = 0;
    cpu_req = 1; cpu_addr = 22'h001000;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_rd_cpu || mem_rd_ppu || mem_wr || busy) bad++;
      step();
    end
    chk("gate_quiet", bad, 0);
    chk("gate_c20_no_strobe", mem_rd_cpu, 0);
    load_done = 1;
    step();
    chk("gate_c21_strobe", mem_rd_cpu, 1);
    step();
    step();
    chk("gate_ack", cpu_ack, 1);
    cpu_req = 0;
    step();
    // load_done drops mid-access: this access completes, then grants stop.
    cpu_req = 1;
    step();
    chk("drop_issue", mem_rd_cpu, 1);
    load_done = 0;
    step();
    step();
    chk("drop_ack", cpu_ack, 1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (mem_rd_cpu || mem_rd_ppu || mem_wr || busy) bad++;
    end
    chk("drop_no_regrant", bad, 0);
    cpu_req = 0;
    load_done = 1;

    // Long latency on the RD_LAT=3 / WR_LAT=2 instance.
    do_reset();
    ppu_req = 1; ppu_we = 0; ppu_addr = 22'h040000; mem_q_ppu = 8'h11;
    step();
    chk("lat3_strobe", d3_mem_rd_ppu, 1);
    step();
    step();
    step();
    chk("lat3_no_early_ack", d3_ppu_ack, 0);
    chk("lat3_no_early_capture", d3_ppu_rdata, 8'h00);
    mem_q_ppu = 8'h77;
    step();
    chk("lat3_ack", d3_ppu_ack, 1);
    chk("lat3_rdata", d3_ppu_rdata, 8'h77);
    ppu_req = 0;
    step();
    ppu_req = 1; ppu_we = 1; ppu_addr = 22'h040001; ppu_wdata = 8'h5C;
    step();
    chk("wlat2_strobe", {d3_mem_wr, d3_mem_d}, {1'b1, 8'h5C});
    step();
    step();
    chk("wlat2_no_early_ack", d3_ppu_ack, 0);
    step();
    chk("wlat2_ack", d3_ppu_ack, 1);
    chk("wlat2_rdata_kept", d3_ppu_rdata, 8'h77);
    ppu_req = 0; ppu_we = 0;

    // Reset while a CPU read sits in WAIT.
    do_reset();
    cpu_req = 1; cpu_addr = 22'h380010; mem_q_cpu = 8'h96;
    step(); step(); step();
    chk("rst_pre_ack", {cpu_ack, cpu_rdata}, {1'b1, 8'h96});
    cpu_req = 0;
    step();
    cpu_req = 1; mem_q_cpu = 8'h3D;
    step();
    chk("rst_issue", mem_rd_cpu, 1);
    step();
    reset = 1;
    step();
    reset = 0; cpu_req = 0;
    chk("rst_outputs_zero",
        {cpu_ack, cpu_rdata, ppu_ack, ppu_rdata, mem_addr, mem_rd_cpu, mem_rd_ppu,
         mem_wr, mem_d, busy}, 64'd0);
    step();
    chk("rst_no_late_ack", {cpu_ack, busy}, 0);
    cpu_req = 1; cpu_addr = 22'h000777; mem_q_cpu = 8'h42;
    step();
    chk("rst_regrant_strobe", {mem_rd_cpu, mem_addr}, {1'b1, 22'h000777});
    step();
    step();
    chk("rst_regrant_ack", {cpu_ack, cpu_rdata}, {1'b1, 8'h42});
    cpu_req = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single NES main-memory port between the CPU and PPU requesters.
- Drives mem_addr, mem_rd_cpu, mem_rd_ppu, mem_wr and mem_d into main_mem.
- Uses 2-way round-robin arbitration with one access outstanding, a req/ack handshake per requester, and latency-compensated read capture.
- Issues no grants until the cartridge load completes.

Parameters:
- ADDR_W, 22, memory address width; matches the main_mem logical space.
- RD_LAT, 1, cycles from the read-strobe edge until mem_q_cpu/mem_q_ppu hold valid data; legal range 1..15.
- WR_LAT, 1, cycles from the mem_wr strobe until the write is committed; legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_done  in  1  cartridge image loaded; grants are inhibited while low
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  CPU read data; valid when cpu_ack is high, then held
- ppu_req  in  1  PPU access request
- ppu_we  in  1  PPU write enable
- ppu_addr  in  ADDR_W  PPU address
- ppu_wdata  in  8  PPU write data
- ppu_ack  out  1  one-cycle completion pulse
- ppu_rdata  out  8  PPU read data
- mem_addr  out  ADDR_W  to main_mem
- mem_rd_cpu  out  1  one-cycle read strobe on the CPU lane
- mem_rd_ppu  out  1  one-cycle read strobe on the PPU lane
- mem_wr  out  1  one-cycle write strobe
- mem_d  out  8  write data
- mem_q_cpu  in  8  main_mem CPU-lane read data
- mem_q_ppu  in  8  main_mem PPU-lane read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, any state):
  - FSM goes to IDLE; last_grant = PPU, so the CPU wins the first tie.
  - All outputs go to 0, including rdata and mem_addr.
  - An in-flight access is abandoned and no ack is issued for it.
- States:
  - IDLE: sample requests. If load_done = 0, stay. Else if exactly one req is high, grant it. If both are high, grant the requester not in last_grant. Latch owner, we, addr and wdata into internal registers, update last_grant, go to ISSUE.
  - ISSUE (one cycle):
    - mem_addr and mem_d are driven from the latched values.
    - On a read, exactly one strobe is asserted: mem_rd_cpu if owner = CPU, else mem_rd_ppu.
    - On a write, mem_wr = 1.
    - Load the counter with RD_LAT or WR_LAT; go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, on a read capture mem_q of the owner lane into that owner's rdata register; go to ACK.
  - ACK (one cycle): pulse owner_ack = 1; go to IDLE.
- Timing:
  - Req sampled in IDLE at cycle R gives the strobe at R+1.
  - Read data is captured on the edge at R+1+RD_LAT; ack is high at R+2+RD_LAT.
  - Write ack is high at R+2+WR_LAT.
- mem_addr and mem_d stay stable from ISSUE through ACK. Strobes are never asserted outside ISSUE.
- Back-to-back: after ACK, IDLE re-arbitrates. A requester must drop req in the cycle after its ack unless it is presenting a new access. Req is ignored during ISSUE, WAIT and ACK.
- Fairness: with both requesting continuously, grants strictly alternate. Maximum wait is one foreign access plus the own access.
- load_done falling mid-access: the current access completes and acks; no further grants until load_done returns high.
- cpu_rdata and ppu_rdata change only on their own read capture. Writes do not alter them.
- Counter is 4 bits. RD_LAT = 0 or WR_LAT = 0 is illegal; flag it with a simulation-only assertion.

Decomposition:
- Shared package nes_mem_pkg:
  - arb_state_t enum: IDLE, ISSUE, WAIT, ACK.
  - ADDR_W = 22.
  - OWNER_CPU = 0, OWNER_PPU = 1.
  - Region prefix constants: PRG 0, CHR 10, VRAM 1100, CPURAM 1110, CARTRAM 1111.
- One sub-module, rr_arb2: combinational 2-way round-robin picker, inputs req[1:0] and last, output grant index and valid.

Test Plan:
- CPU read, RD_LAT=1, load_done=1: cpu_req at cycle 0 with addr 22'h380010 and mem_q_cpu returning 8'hA5 -> mem_rd_cpu high only at cycle 1, mem_addr = 22'h380010, cpu_ack at cycle 3, cpu_rdata = 8'hA5, ppu_ack never asserted.
- PPU write, WR_LAT=1: ppu_req with we=1, addr 22'h300123, wdata 8'h3C -> mem_wr high only at cycle 1 with mem_d = 8'h3C, ppu_ack at cycle 3, ppu_rdata unchanged.
- Contention: cpu_req and ppu_req held high together for 8 accesses, starting after reset -> grant order CPU, PPU, CPU, PPU…, and each ack pulses exactly once per access.
- Load gating: load_done = 0 with cpu_req high for 20 cycles -> no strobes and busy = 0. Raise load_done at cycle 20 -> strobe at cycle 21.
- RD_LAT=3: PPU read with mem_q_ppu = 8'h11 until the capture edge and 8'h77 at it -> ppu_rdata = 8'h77, ppu_ack at R+5.
- Reset in WAIT: assert reset for one cycle during a CPU read -> the next cycle shows all outputs 0 and state IDLE, no cpu_ack for the abandoned read, and the next cpu_req is granted normally.
